// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Address map matches the 4-entry register memory in the datapath.
package alu_seq_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [1:0] ADDR_RES = 2'd0;
  localparam logic [1:0] ADDR_A   = 2'd1;
  localparam logic [1:0] ADDR_B   = 2'd2;
  localparam logic [1:0] ADDR_OP  = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_A  = 3'd1,
    WR_B  = 3'd2,
    WR_OP = 3'd3,
    EXEC  = 3'd4,
    RD    = 3'd5,
    RESP  = 3'd6
  } state_e;

  // Datapath control pins, registered as one bundle.
  typedef struct packed {
    logic       cs;
    logic       wr_enb;
    logic       rd_enb;
    logic [1:0] addr;
    logic       op_start;
  } dp_ctl_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Sequences one {a, b, op} command into datapath pin activity (write A, B, OP,
// fire, read result) and returns the result over a valid/ready handshake.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DW     = 4,
  parameter int WR_CYC = 2,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DW-1:0]       cmd_a,
  input  logic [DW-1:0]       cmd_b,
  input  logic [OPCODE_W-1:0] cmd_op,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DW-1:0]       rsp_result,
  output logic                busy,
  output logic [7:0]          op_count,
  output logic                dp_cs,
  output logic                dp_wr_enb,
  output logic                dp_rd_enb,
  output logic [1:0]          dp_addr,
  output logic [DW-1:0]       dp_wr_data,
  output logic                dp_op_start,
  input  logic [DW-1:0]       dp_rd_data
);

  if (WR_CYC < 1 || WR_CYC > 15) begin : g_bad_wr_cyc
    $error("alu_op_sequencer: WR_CYC=%0d outside 1..15", WR_CYC);
  end
  if (RD_LAT < 0 || RD_LAT > 14) begin : g_bad_rd_lat
    $error("alu_op_sequencer: RD_LAT=%0d outside 0..14", RD_LAT);
  end
  if (DW < 1) begin : g_bad_dw
    $error("alu_op_sequencer: DW=%0d must be positive", DW);
  end

  localparam logic [3:0] WR_RLD = 4'(WR_CYC - 1);
  localparam logic [3:0] RD_RLD = 4'(RD_LAT);

  state_e              state_q, state_n;
  logic [3:0]          hold_q, hold_n;
  logic [DW-1:0]       a_q, b_q;
  logic [OPCODE_W-1:0] op_q;
  logic [DW-1:0]       res_q;
  logic [7:0]          cnt_q;
  dp_ctl_t             dp_q, dp_n;
  logic [DW-1:0]       wdata_q, wdata_n;
  logic                hold_last;

  assign hold_last = (hold_q == 4'd0);

  // Pins are decoded from the *next* state and registered, so they line up
  // with the state they belong to and never glitch.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_n = WR_A;
      WR_A:    if (hold_last) state_n = WR_B;
      WR_B:    if (hold_last) state_n = WR_OP;
      WR_OP:   if (hold_last) state_n = EXEC;
      EXEC:    state_n = RD;
      RD:      if (hold_last) state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    hold_n = hold_last ? 4'd0 : hold_q - 4'd1;
    if (state_n != state_q) begin
      case (state_n)
        WR_A, WR_B, WR_OP: hold_n = WR_RLD;
        RD:                hold_n = RD_RLD;
        default:           hold_n = 4'd0;
      endcase
    end

    dp_n    = '0;
    wdata_n = '0;
    case (state_n)
      WR_A: begin
        dp_n.cs     = 1'b1;
        dp_n.wr_enb = 1'b1;
        dp_n.addr   = ADDR_A;
        // Entering from IDLE the operand is not latched yet.
        wdata_n     = (state_q == IDLE) ? cmd_a : a_q;
      end
      WR_B: begin
        dp_n.cs     = 1'b1;
        dp_n.wr_enb = 1'b1;
        dp_n.addr   = ADDR_B;
        wdata_n     = b_q;
      end
      WR_OP: begin
        dp_n.cs     = 1'b1;
        dp_n.wr_enb = 1'b1;
        dp_n.addr   = ADDR_OP;
        wdata_n     = DW'(op_q);
      end
      EXEC: dp_n.op_start = 1'b1;
      RD: begin
        dp_n.cs     = 1'b1;
        dp_n.rd_enb = 1'b1;
        dp_n.addr   = ADDR_RES;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      dp_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_n;
      hold_q  <= hold_n;
      dp_q    <= dp_n;
      wdata_q <= wdata_n;
      if (state_q == IDLE && cmd_valid) begin
        a_q  <= cmd_a;
        b_q  <= cmd_b;
        op_q <= cmd_op;
      end
      if (state_q == RD && hold_last) res_q <= dp_rd_data;
      if (state_q == RESP && rsp_ready) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_result  = res_q;
  assign op_count    = cnt_q;
  assign dp_cs       = dp_q.cs;
  assign dp_wr_enb   = dp_q.wr_enb;
  assign dp_rd_enb   = dp_q.rd_enb;
  assign dp_addr     = dp_q.addr;
  assign dp_op_start = dp_q.op_start;
  assign dp_wr_data  = wdata_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: default-parameter sequencer driving a small memory/ALU model,
// plus two extra instances for the WR_CYC/RD_LAT sweep.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  logic [3:0] cmd_a, cmd_b, cmd_op, rsp_result, dp_wr_data, dp_rd_data;
  logic [7:0] op_count;
  logic       dp_cs, dp_wr_enb, dp_rd_enb, dp_op_start;
  logic [1:0] dp_addr;

  logic [1:0]       sv_cmd_valid, sv_cmd_ready, sv_rsp_valid, sv_busy;
  logic [1:0]       sv_cs, sv_wr, sv_rd, sv_opst;
  logic [1:0][1:0]  sv_addr;
  logic [1:0][3:0]  sv_res, sv_wdata, sv_rdd;
  logic [1:0][7:0]  sv_cnt;

  int errors = 0;
  int checks = 0;
  int excl_viol = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DW(4), .WR_CYC(2), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .busy(busy), .op_count(op_count),
    .dp_cs(dp_cs), .dp_wr_enb(dp_wr_enb), .dp_rd_enb(dp_rd_enb), .dp_addr(dp_addr),
    .dp_wr_data(dp_wr_data), .dp_op_start(dp_op_start), .dp_rd_data(dp_rd_data)
  );

  alu_op_sequencer #(.DW(4), .WR_CYC(1), .RD_LAT(0)) u_sw0 (
    .clk(clk), .rst(rst), .cmd_valid(sv_cmd_valid[0]), .cmd_ready(sv_cmd_ready[0]),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .rsp_valid(sv_rsp_valid[0]),
    .rsp_ready(rsp_ready), .rsp_result(sv_res[0]), .busy(sv_busy[0]), .op_count(sv_cnt[0]),
    .dp_cs(sv_cs[0]), .dp_wr_enb(sv_wr[0]), .dp_rd_enb(sv_rd[0]), .dp_addr(sv_addr[0]),
    .dp_wr_data(sv_wdata[0]), .dp_op_start(sv_opst[0]), .dp_rd_data(sv_rdd[0])
  );

  alu_op_sequencer #(.DW(4), .WR_CYC(4), .RD_LAT(3)) u_sw1 (
    .clk(clk), .rst(rst), .cmd_valid(sv_cmd_valid[1]), .cmd_ready(sv_cmd_ready[1]),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .rsp_valid(sv_rsp_valid[1]),
    .rsp_ready(rsp_ready), .rsp_result(sv_res[1]), .busy(sv_busy[1]), .op_count(sv_cnt[1]),
    .dp_cs(sv_cs[1]), .dp_wr_enb(sv_wr[1]), .dp_rd_enb(sv_rd[1]), .dp_addr(sv_addr[1]),
    .dp_wr_data(sv_wdata[1]), .dp_op_start(sv_opst[1]), .dp_rd_data(sv_rdd[1])
  );

  // Datapath model: 4x4 memory, ALU result lands in address 0 on op_start.
  logic [3:0] mem [4];
  initial for (int i = 0; i < 4; i++) mem[i] = 4'd0;

  function automatic logic [3:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (dp_cs && dp_wr_enb) mem[dp_addr] <= dp_wr_data;
    else if (dp_op_start)   mem[0] <= alu(mem[1], mem[2], mem[3]);
  end
  assign dp_rd_data = dp_rd_enb ? mem[dp_addr] : 4'd0;
  assign sv_rdd[0]  = sv_rd[0] ? 4'hA : 4'h0;
  assign sv_rdd[1]  = sv_rd[1] ? 4'hA : 4'h0;

  always @(negedge clk) begin
    if ((dp_wr_enb && dp_rd_enb) || (dp_op_start && (dp_wr_enb || dp_rd_enb)) ||
        (sv_wr != 2'b00 && (sv_wr & sv_rd) != 2'b00) || ((sv_opst & (sv_wr | sv_rd)) != 2'b00))
      excl_viol <= excl_viol + 1;
  end

  task automatic test_reset();
    logic [24:0] got;
    rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; sv_cmd_valid = '0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0;
    repeat (2) @(negedge clk);
    got = {cmd_ready, rsp_valid, busy, op_count, rsp_result, dp_cs, dp_wr_enb,
           dp_rd_enb, dp_addr, dp_wr_data, dp_op_start};
    checks++;
    if (got !== {1'b1, 24'd0}) begin
      errors++; $display("FAIL reset_state: got %h want %h", got, {1'b1, 24'd0});
    end
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic [10:0] got, exp;
    @(negedge clk);
    cmd_a = 4'd3; cmd_b = 4'd5; cmd_op = 4'd0; cmd_valid = 1'b1; rsp_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      got = {dp_cs, dp_wr_enb, dp_rd_enb, dp_addr, dp_wr_data, dp_op_start, rsp_valid};
      case (k)
        1, 2:    exp = {3'b110, 2'd1, 4'd3, 1'b0, 1'b0};
        3, 4:    exp = {3'b110, 2'd2, 4'd5, 1'b0, 1'b0};
        5, 6:    exp = {3'b110, 2'd3, 4'd0, 1'b0, 1'b0};
        7:       exp = {3'b000, 2'd0, 4'd0, 1'b1, 1'b0};
        8, 9:    exp = {3'b101, 2'd0, 4'd0, 1'b0, 1'b0};
        default: exp = {3'b000, 2'd0, 4'd0, 1'b0, 1'b1};
      endcase
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL single_cyc%0d: got %h want %h", k, got, exp);
      end
      if (k == 1) begin
        cmd_valid = 1'b0; cmd_a = 4'hF; cmd_b = 4'hF; cmd_op = 4'hF;
      end
    end
    checks++;
    if (rsp_result !== 4'd8) begin
      errors++; $display("FAIL single_result: got %0d want 8", rsp_result);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({op_count, cmd_ready, rsp_valid, busy} !== {8'd1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_done: got cnt=%0d rdy=%b vld=%b busy=%b want cnt=1 rdy=1 vld=0 busy=0",
               op_count, cmd_ready, rsp_valid, busy);
    end
  endtask

  task automatic test_reset_midop();
    logic [24:0] got;
    int vld_seen = 0;
    @(negedge clk);
    cmd_a = 4'd4; cmd_b = 4'd4; cmd_op = 4'd0; cmd_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    got = {cmd_ready, rsp_valid, busy, op_count, rsp_result, dp_cs, dp_wr_enb,
           dp_rd_enb, dp_addr, dp_wr_data, dp_op_start};
    checks++;
    if (got !== {1'b1, 24'd0}) begin
      errors++; $display("FAIL midop_reset: got %h want %h", got, {1'b1, 24'd0});
    end
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid || busy) vld_seen++;
    end
    rsp_ready = 1'b0;
    checks++;
    if (vld_seen !== 0) begin
      errors++; $display("FAIL midop_no_resp: got %0d active cycles want 0", vld_seen);
    end
  endtask

  task automatic test_backpressure();
    logic [13:0] got, exp;
    int wait_cyc = 0;
    @(negedge clk);
    cmd_a = 4'd2; cmd_b = 4'd6; cmd_op = 4'd2; cmd_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!rsp_valid && wait_cyc < 20) begin
      @(negedge clk); wait_cyc++;
    end
    checks++;
    if (!rsp_valid) begin
      errors++; $display("FAIL bp_timeout: got no rsp_valid want rsp_valid within 20 cycles");
    end
    exp = {1'b1, 4'd2, 1'b0, 1'b1, 3'b000, 2'd0, 1'b0};
    for (int k = 0; k < 20; k++) begin
      got = {rsp_valid, rsp_result, cmd_ready, busy, dp_cs, dp_wr_enb, dp_rd_enb,
             dp_addr, dp_op_start};
      checks++;
      if (got !== exp || dp_wr_data !== 4'd0) begin
        errors++; $display("FAIL bp_hold%0d: got %h/%h want %h/0", k, got, dp_wr_data, exp);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid, op_count} !== {1'b1, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b vld=%b cnt=%0d want rdy=1 vld=0 cnt=1",
               cmd_ready, rsp_valid, op_count);
    end
  endtask

  task automatic test_sweep();
    int lat, nwr, nrd;
    int exp_lat, exp_wr, exp_rd;
    for (int i = 0; i < 2; i++) begin
      exp_lat = (i == 0) ? 6 : 18;
      exp_wr  = (i == 0) ? 3 : 12;
      exp_rd  = (i == 0) ? 1 : 4;
      lat = 0; nwr = 0; nrd = 0;
      @(negedge clk);
      rsp_ready = 1'b1; sv_cmd_valid[i] = 1'b1;
      for (int k = 1; k <= 30 && lat == 0; k++) begin
        @(negedge clk);
        if (k == 1) sv_cmd_valid[i] = 1'b0;
        if (sv_wr[i]) nwr++;
        if (sv_rd[i]) nrd++;
        if (sv_rsp_valid[i]) begin
          lat = k;
          checks++;
          if (sv_res[i] !== 4'hA) begin
            errors++; $display("FAIL sweep%0d_result: got %h want a", i, sv_res[i]);
          end
        end
      end
      checks++;
      if (lat !== exp_lat) begin
        errors++; $display("FAIL sweep%0d_latency: got %0d want %0d", i, lat, exp_lat);
      end
      checks++;
      if (nwr !== exp_wr || nrd !== exp_rd) begin
        errors++;
        $display("FAIL sweep%0d_windows: got wr=%0d rd=%0d want wr=%0d rd=%0d",
                 i, nwr, nrd, exp_wr, exp_rd);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] ca [3] = '{4'd7, 4'd9, 4'd6};
    logic [3:0] cb [3] = '{4'd2, 4'd12, 4'd3};
    logic [3:0] co [3] = '{4'd1, 4'd2, 4'd3};
    logic [3:0] cr [3] = '{4'd5, 4'd8, 4'd7};
    int acc [3];
    int nacc = 0, nrsp = 0, cur = -1;
    logic [3:0] exp_d;
    rsp_ready = 1'b1;
    for (int c = 0; c < 60 && nrsp < 3; c++) begin
      @(negedge clk);
      if (dp_wr_enb && cur >= 0) begin
        exp_d = (dp_addr == 2'd1) ? ca[cur] : (dp_addr == 2'd2) ? cb[cur] : co[cur];
        checks++;
        if (dp_wr_data !== exp_d) begin
          errors++;
          $display("FAIL b2b_wdata c%0d addr%0d: got %h want %h", c, dp_addr, dp_wr_data, exp_d);
        end
      end
      if (rsp_valid) begin
        checks++;
        if (rsp_result !== cr[nrsp]) begin
          errors++; $display("FAIL b2b_result%0d: got %0d want %0d", nrsp, rsp_result, cr[nrsp]);
        end
        nrsp++;
      end
      if (cmd_ready && nacc < 3) begin
        cmd_a = ca[nacc]; cmd_b = cb[nacc]; cmd_op = co[nacc]; cmd_valid = 1'b1;
        acc[nacc] = c; cur = nacc; nacc++;
      end else begin
        cmd_valid = (nacc < 3);
        cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 4'($urandom);
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (nrsp !== 3 || nacc !== 3) begin
      errors++; $display("FAIL b2b_count: got acc=%0d rsp=%0d want 3/3", nacc, nrsp);
    end else begin
      checks++;
      if (acc[1] - acc[0] !== 11 || acc[2] - acc[1] !== 11) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d,%0d want 11,11", acc[1] - acc[0], acc[2] - acc[1]);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (op_count !== 8'd4) begin
      errors++; $display("FAIL b2b_op_count: got %0d want 4", op_count);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    cmd_a = 4'd1; cmd_b = 4'd1; cmd_op = 4'd0; cmd_valid = 1'b1; rsp_ready = 1'b1;
    while (op_count != 8'd255 && n < 4000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (op_count !== 8'd255) begin
      errors++; $display("FAIL wrap_reach: got %0d want 255", op_count);
    end
    n = 0;
    while (op_count == 8'd255 && n < 20) begin
      @(negedge clk); n++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (op_count !== 8'd0) begin
      errors++; $display("FAIL wrap_zero: got %0d want 0", op_count);
    end
    repeat (15) @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (excl_viol !== 0) begin
      errors++; $display("FAIL mutual_excl: got %0d violations want 0", excl_viol);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_midop();
    test_backpressure();
    test_sweep();
    test_back_to_back();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-level front end for the memory/ALU datapath (4-entry x 4-bit register memory, ALU, result write-back to address 0).
- Accepts one {a, b, opcode} command over a valid/ready handshake.
- Drives the datapath's cs/wr_enb/rd_enb/addr/wr_data/op_start pins to load operands, fire the operation and read back the result.
- Returns the result over a second valid/ready handshake. Replaces hand-driven pin sequencing in system-level benches and software-facing wrappers.

Parameters:
- DW, 4, operand/result width; must match datapath data width.
- WR_CYC, 2, cycles each operand write is held (cs=wr_enb=1, addr/wr_data stable); legal range 1..15.
- RD_LAT, 1, cycles from read-request start until rd_data is valid; legal range 0..14.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept command
- cmd_a  in  DW  operand A
- cmd_b  in  DW  operand B
- cmd_op  in  4  ALU opcode
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_result  out  DW  result read from address 0
- busy  out  1  high in every state except IDLE
- op_count  out  8  completed operations, wraps 255->0
- dp_cs  out  1  datapath chip select
- dp_wr_enb  out  1  datapath write enable
- dp_rd_enb  out  1  datapath read enable
- dp_addr  out  2  datapath address
- dp_wr_data  out  DW  datapath write data
- dp_op_start  out  1  datapath op_start
- dp_rd_data  in  DW  datapath read data

Behaviour:
- Reset (rst=0 at an edge): state IDLE; all outputs 0 except cmd_ready=1. This includes op_count, rsp_result and all dp_* pins. Reset mid-operation aborts with no partial response; memory contents are left as-is.
- Address map: ADDR_RES=0, ADDR_A=1, ADDR_B=2, ADDR_OP=3.
- IDLE: cmd_ready=1. On cmd_valid & cmd_ready, latch a/b/op, then go to WR_A.
- WR_A / WR_B / WR_OP: each lasts WR_CYC cycles.
  - Pins: dp_cs=1, dp_wr_enb=1, dp_addr=ADDR_A/ADDR_B/ADDR_OP, dp_wr_data=latched a/b/op zero-extended to DW.
  - A 4-bit hold counter reloads on every state entry.
- EXEC: exactly 1 cycle.
  - Pins: dp_op_start=1, dp_cs=0, dp_wr_enb=0, dp_addr=0, dp_wr_data=0.
  - The datapath writes the ALU result to address 0 at this edge.
- RD: lasts RD_LAT+1 cycles.
  - Pins: dp_cs=1, dp_rd_enb=1, dp_addr=ADDR_RES.
  - dp_rd_data is captured into rsp_result at the final RD edge.
- RESP: rsp_valid=1; rsp_result held stable while rsp_ready=0 (unbounded backpressure).
  - On rsp_valid & rsp_ready: op_count increments and state returns to IDLE. cmd_ready rises the following cycle; there is no same-cycle turnaround.
- In any state not listed above, every dp_* pin is 0. dp_wr_enb and dp_rd_enb are never high together; dp_op_start is never high together with either.
- Latency: accept edge E0; rsp_valid first high in cycle 3*WR_CYC + RD_LAT + 3 (10 at defaults).
- Throughput: one command per 3*WR_CYC + RD_LAT + 4 cycles at best.
- cmd_* inputs are ignored outside IDLE; the latched copy is used throughout.
- Out-of-range parameters are flagged by an elaboration-time check.

Decomposition:
- Shared package alu_seq_pkg:
  - state enum {IDLE, WR_A, WR_B, WR_OP, EXEC, RD, RESP}
  - address constants ADDR_RES/ADDR_A/ADDR_B/ADDR_OP
  - OPCODE_W=4
- No sub-module. The hold counter and the op_count counter stay inline; the FSM is a single next-state block plus registered outputs (no combinational dp_* glitches).

Test Plan:
- Reset: hold rst=0 for 2 cycles during WR_B -> next cycle all dp_*=0, busy=0, cmd_ready=1, op_count=0; rsp_valid never asserts.
- Single op (defaults): cmd a=3, b=5, op=0; datapath model returns dp_rd_data=8 during RD.
  - dp writes are (1,3) for cycles 1-2, (2,5) for cycles 3-4, (3,0) for cycles 5-6.
  - dp_op_start=1 in cycle 7 only; dp_rd_enb=1 with addr 0 in cycles 8-9.
  - rsp_valid=1 in cycle 10 with rsp_result=8; op_count=1 after handshake.
- Backpressure: hold rsp_ready=0 for 20 cycles -> rsp_valid and rsp_result constant, cmd_ready=0, no dp_* activity; rsp_ready=1 -> IDLE next cycle.
- Parameter sweep: WR_CYC=1, RD_LAT=0 -> rsp_valid at cycle 6. WR_CYC=4, RD_LAT=3 -> rsp_valid at cycle 18. Write/read windows scale as specified.
- Back-to-back with rsp_ready=1: 3 commands -> accepts spaced exactly 11 cycles apart at defaults; cmd_* changes mid-sequence do not affect dp_wr_data.
- Counter wrap: 256 completed ops -> op_count returns to 0; mutual-exclusion assertions on dp_wr_enb/dp_rd_enb/dp_op_start never fire.
